// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
`timescale 1ns/1ps
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchronizer bringing the asynchronous serial line into the clk domain.
// Flops reset to 1 so an idle (high) line is never mistaken for a start bit.
`timescale 1ns/1ps
module rx_sync
    import uart_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw line in at the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    // Synchronizer register chain, idle-high after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ascii.sv
// 8N1 UART receiver: oversampled start/data/stop detection, LSB-first
// deserialization, valid/ready character output, framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_rx_ascii
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [7:0]           char_data_q, char_data_d;
    logic                 char_valid_q, char_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    rx_sync u_rx_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (rx_in),
        .sync_out (rx_s)
    );

    // Next-state logic: frame FSM, bit timing, shifting and output-register handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        char_data_d  = char_data_q;
        char_valid_d = char_valid_q;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        if (char_valid_q && char_ready) begin
            char_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        if (!char_valid_q || char_ready) begin
                            char_data_d  = shreg_q;
                            char_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shreg_q      <= '0;
            char_data_q  <= '0;
            char_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            char_data_q  <= char_data_d;
            char_valid_q <= char_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign char_data  = char_data_q;
    assign char_valid = char_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule
